// File: rtl/program_loader.sv
// Boot-time program loader: parses a header/data/checksum byte stream from the host
// link, writes each data byte with a setup/strobe/hold cycle, then releases the CPU.
module program_loader (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  IN_DATA,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic [15:0] MEM_ADDR,
   output logic [7:0]  MEM_DATA,
   output logic        MEM_WE_bar,
   output logic        BUS_OE_bar,
   output logic        CPU_RST_bar,
   output logic        DONE,
   output logic        ERR
);

   typedef enum logic [3:0] {
      S_ADDR_HI = 4'd0,
      S_ADDR_LO = 4'd1,
      S_LEN_HI  = 4'd2,
      S_LEN_LO  = 4'd3,
      S_DATA    = 4'd4,
      S_SETUP   = 4'd5,
      S_STROBE  = 4'd6,
      S_HOLD    = 4'd7,
      S_CHECK   = 4'd8,
      S_DONE    = 4'd9,
      S_ERROR   = 4'd10
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_hdr_addr;
   logic [15:0] r_count;
   logic [7:0]  r_csum;
   logic        w_xfer;
   logic        w_ready_nxt;
   logic        w_we_bar_nxt;
   logic        w_oe_bar_nxt;
   logic        w_cpu_rst_bar_nxt;
   logic        w_done_nxt;
   logic        w_err_nxt;

   assign w_xfer = IN_VALID & IN_READY;

   // Next-state decode; outputs are decoded from the next state so the registers match the state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_ADDR_HI: if (w_xfer) w_next = S_ADDR_LO; else w_next = r_state;
         S_ADDR_LO: if (w_xfer) w_next = S_LEN_HI;  else w_next = r_state;
         S_LEN_HI:  if (w_xfer) w_next = S_LEN_LO;  else w_next = r_state;
         S_LEN_LO: begin
            if (w_xfer) begin
               if ({r_count[15:8], IN_DATA} == 16'h0000) w_next = S_CHECK;
               else                                      w_next = S_DATA;
            end else begin
               w_next = r_state;
            end
         end
         S_DATA:    if (w_xfer) w_next = S_SETUP; else w_next = r_state;
         S_SETUP:   w_next = S_STROBE;
         S_STROBE:  w_next = S_HOLD;
         S_HOLD: begin
            if (r_count != 16'h0000) w_next = S_DATA;
            else                     w_next = S_CHECK;
         end
         S_CHECK: begin
            if (w_xfer) begin
               if (IN_DATA == r_csum) w_next = S_DONE;
               else                   w_next = S_ERROR;
            end else begin
               w_next = r_state;
            end
         end
         S_DONE:    w_next = S_DONE;
         S_ERROR:   w_next = S_ERROR;
         default:   w_next = S_ADDR_HI;
      endcase

      w_ready_nxt       = 1'b0;
      w_we_bar_nxt      = 1'b1;
      w_oe_bar_nxt      = 1'b0;
      w_cpu_rst_bar_nxt = 1'b0;
      w_done_nxt        = 1'b0;
      w_err_nxt         = 1'b0;
      case (w_next)
         S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: w_ready_nxt = 1'b1;
         S_STROBE: w_we_bar_nxt = 1'b0;
         S_DONE: begin
            w_done_nxt        = 1'b1;
            w_cpu_rst_bar_nxt = 1'b1;
            w_oe_bar_nxt      = 1'b1;
         end
         S_ERROR: begin
            w_err_nxt    = 1'b1;
            w_oe_bar_nxt = 1'b1;
         end
         default: w_ready_nxt = 1'b0;
      endcase
   end

   // State and registered control outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_ADDR_HI;
         IN_READY    <= 1'b0;
         MEM_WE_bar  <= 1'b1;
         BUS_OE_bar  <= 1'b0;
         CPU_RST_bar <= 1'b0;
         DONE        <= 1'b0;
         ERR         <= 1'b0;
      end else begin
         r_state     <= w_next;
         IN_READY    <= w_ready_nxt;
         MEM_WE_bar  <= w_we_bar_nxt;
         BUS_OE_bar  <= w_oe_bar_nxt;
         CPU_RST_bar <= w_cpu_rst_bar_nxt;
         DONE        <= w_done_nxt;
         ERR         <= w_err_nxt;
      end
   end

   // Header capture, memory bus drive, byte count and checksum.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hdr_addr <= 16'h0000;
         r_count    <= 16'h0000;
         r_csum     <= 8'h00;
         MEM_ADDR   <= 16'h0000;
         MEM_DATA   <= 8'h00;
      end else begin
         case (r_state)
            S_ADDR_HI: if (w_xfer) r_hdr_addr[15:8] <= IN_DATA;
            S_ADDR_LO: if (w_xfer) r_hdr_addr[7:0]  <= IN_DATA;
            S_LEN_HI: begin
               if (w_xfer) begin
                  MEM_ADDR      <= r_hdr_addr;
                  r_count[15:8] <= IN_DATA;
               end
            end
            S_LEN_LO:  if (w_xfer) r_count[7:0] <= IN_DATA;
            S_DATA: begin
               if (w_xfer) begin
                  MEM_DATA <= IN_DATA;
                  r_csum   <= r_csum + IN_DATA;
                  r_count  <= r_count - 16'd1;
               end
            end
            S_HOLD:    MEM_ADDR <= MEM_ADDR + 16'd1;
            default:   r_csum   <= r_csum;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader: streams, write log and final status checks.
module tb_program_loader;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  IN_DATA = 8'h00;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [15:0] MEM_ADDR;
   logic [7:0]  MEM_DATA;
   logic        MEM_WE_bar;
   logic        BUS_OE_bar;
   logic        CPU_RST_bar;
   logic        DONE;
   logic        ERR;

   program_loader dut (
      .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WE_bar(MEM_WE_bar),
      .BUS_OE_bar(BUS_OE_bar), .CPU_RST_bar(CPU_RST_bar), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // stream: first byte in s[63:56]; expected writes: first in wa[47:32] / wd[23:16]
   typedef struct {
      int          n;
      logic [63:0] s;
      int          nw;
      logic [47:0] wa;
      logic [23:0] wd;
      logic        done;
   } vec_t;

   vec_t vecs [0:6];

   int total = 0;
   int bad   = 0;

   logic [15:0] wl_a [0:15];
   logic [7:0]  wl_d [0:15];
   int          wl_n = 0;

   logic [15:0] p_addr = 16'h0000;
   logic [7:0]  p_data = 8'h00;
   logic        p_we   = 1'b1;
   bit          rst_edge = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge CLK) rst_edge = RST;

   // Write monitor: logs strobes and checks bus stability around each one.
   always @(negedge CLK) begin
      if (rst_edge) begin
         p_we = 1'b1;
      end else begin
         if (MEM_WE_bar === 1'b0) begin
            chk("strobe_single_cycle", {31'd0, p_we}, 32'd1);
            chk("strobe_addr_stable", {16'd0, MEM_ADDR}, {16'd0, p_addr});
            chk("strobe_data_stable", {24'd0, MEM_DATA}, {24'd0, p_data});
            if (wl_n < 16) begin
               wl_a[wl_n] = MEM_ADDR;
               wl_d[wl_n] = MEM_DATA;
            end
            wl_n++;
         end else if (p_we === 1'b0) begin
            chk("hold_addr_stable", {16'd0, MEM_ADDR}, {16'd0, p_addr});
            chk("hold_data_stable", {24'd0, MEM_DATA}, {24'd0, p_data});
         end
         p_we = MEM_WE_bar;
      end
      p_addr = MEM_ADDR;
      p_data = MEM_DATA;
   end

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      IN_VALID = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", {31'd0, IN_READY}, 32'd0);
      chk("rst_we_bar", {31'd0, MEM_WE_bar}, 32'd1);
      chk("rst_oe_bar", {31'd0, BUS_OE_bar}, 32'd0);
      chk("rst_cpu_rst_bar", {31'd0, CPU_RST_bar}, 32'd0);
      chk("rst_done_err", {30'd0, DONE, ERR}, 32'd0);
      chk("rst_addr", {16'd0, MEM_ADDR}, 32'd0);
      chk("rst_data", {24'd0, MEM_DATA}, 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      chk("ready_after_rst", {31'd0, IN_READY}, 32'd1);
   endtask

   task automatic send(input logic [7:0] b);
      int w;
      w = 0;
      @(negedge CLK);
      IN_DATA  = b;
      IN_VALID = 1'b1;
      while (IN_READY !== 1'b1 && w < 20) begin
         @(negedge CLK);
         w++;
      end
      if (IN_READY !== 1'b1) chk("send_timeout", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
   endtask

   task automatic run_vec(input int idx, input bit with_reset, input bit gaps);
      vec_t v;
      int   w;
      v = vecs[idx];
      if (with_reset) do_reset();
      wl_n = 0;
      for (int k = 0; k < v.n; k++) begin
         if (gaps) repeat ($urandom_range(0, 3)) @(negedge CLK);
         send(v.s[8*(7-k) +: 8]);
      end
      w = 0;
      @(negedge CLK);
      while (DONE !== 1'b1 && ERR !== 1'b1 && w < 20) begin
         @(negedge CLK);
         w++;
      end
      repeat (3) @(negedge CLK);
      chk($sformatf("v%0d_nwrites", idx), wl_n, v.nw);
      for (int k = 0; k < v.nw && k < wl_n; k++) begin
         chk($sformatf("v%0d_waddr%0d", idx, k), {16'd0, wl_a[k]}, {16'd0, v.wa[16*(2-k) +: 16]});
         chk($sformatf("v%0d_wdata%0d", idx, k), {24'd0, wl_d[k]}, {24'd0, v.wd[8*(2-k) +: 8]});
      end
      chk($sformatf("v%0d_done", idx), {31'd0, DONE}, {31'd0, v.done});
      chk($sformatf("v%0d_err", idx), {31'd0, ERR}, {31'd0, ~v.done});
      chk($sformatf("v%0d_cpu_rst_bar", idx), {31'd0, CPU_RST_bar}, {31'd0, v.done});
      chk($sformatf("v%0d_oe_bar", idx), {31'd0, BUS_OE_bar}, 32'd1);
      chk($sformatf("v%0d_ready", idx), {31'd0, IN_READY}, 32'd0);
   endtask

   initial begin
      int w;
      vecs[0] = '{n: 7, s: 64'h12340002AA55FF00, nw: 2, wa: 48'h1234_1235_0000, wd: 24'hAA5500, done: 1'b1};
      vecs[1] = '{n: 7, s: 64'hFFFF000201020300, nw: 2, wa: 48'hFFFF_0000_0000, wd: 24'h010200, done: 1'b1};
      vecs[2] = '{n: 5, s: 64'h0000000000000000, nw: 0, wa: 48'h0, wd: 24'h0, done: 1'b1};
      vecs[3] = '{n: 5, s: 64'h0000000001000000, nw: 0, wa: 48'h0, wd: 24'h0, done: 1'b0};
      vecs[4] = '{n: 6, s: 64'h8000000110110000, nw: 1, wa: 48'h8000_0000_0000, wd: 24'h100000, done: 1'b0};
      vecs[5] = '{n: 7, s: 64'h00200002F0201000, nw: 2, wa: 48'h0020_0021_0000, wd: 24'hF02000, done: 1'b1};
      vecs[6] = '{n: 8, s: 64'h0040000311223366, nw: 3, wa: 48'h0040_0041_0042, wd: 24'h112233, done: 1'b1};

      for (int i = 0; i < 7; i++) run_vec(i, 1'b1, 1'b0);

      // Same 3-byte image with random idle gaps on IN_VALID.
      run_vec(6, 1'b1, 1'b1);

      // Reset in the middle of a write strobe, then reload without another reset.
      do_reset();
      send(8'h12); send(8'h34); send(8'h00); send(8'h02); send(8'hAA);
      w = 0;
      @(negedge CLK);
      while (MEM_WE_bar !== 1'b0 && w < 10) begin
         @(negedge CLK);
         w++;
      end
      chk("midwrite_strobe_seen", {31'd0, MEM_WE_bar}, 32'd0);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("midwrite_we_bar", {31'd0, MEM_WE_bar}, 32'd1);
      chk("midwrite_addr", {16'd0, MEM_ADDR}, 32'd0);
      chk("midwrite_ready", {31'd0, IN_READY}, 32'd0);
      chk("midwrite_oe_bar", {31'd0, BUS_OE_bar}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      run_vec(0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-003 IN_DATA  input  8  byte from the host link.
REQ-004 IN_VALID  input  1  IN_DATA holds a valid byte.
REQ-005 IN_READY  output  1  loader accepts a byte; transfer occurs on any CLK edge where IN_VALID=1 and IN_READY=1.
REQ-006 MEM_ADDR  output  16  memory address bus drive.
REQ-007 MEM_DATA  output  8  memory data bus drive.
REQ-008 MEM_WE_bar  output  1  active-low memory write strobe.
REQ-009 BUS_OE_bar  output  1  active-low enable for the loader's drivers on the memory address and data buses.
REQ-010 CPU_RST_bar  output  1  active-low reset to the processor core.
REQ-011 DONE  output  1  image loaded and checksum correct.
REQ-012 ERR  output  1  checksum mismatch.

Function
REQ-013 The loader SHALL accept a byte stream with this layout: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN data bytes, then one CHECK byte.
REQ-014 The states SHALL be: S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_SETUP, S_STROBE, S_HOLD, S_CHECK, S_DONE, S_ERROR.
REQ-015 IN_READY SHALL be a Moore output: 1 in S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA and S_CHECK; 0 in all other states.
REQ-016 Header states SHALL latch the accepted byte into the address register or the 16-bit remaining-count register (HI byte first), then advance one state per accepted byte.
REQ-017 On accepting LEN_LO:
- if the assembled length is 0x0000, the next state SHALL be S_CHECK;
- otherwise the next state SHALL be S_DATA.
REQ-018 On accepting a byte in S_DATA, the loader SHALL:
- latch the byte into MEM_DATA;
- add the byte to an 8-bit checksum (modulo 256);
- decrement the remaining count;
- go to S_SETUP.
REQ-019 Write cycle timing:
- S_SETUP: MEM_WE_bar=1, MEM_ADDR and MEM_DATA stable;
- S_STROBE: MEM_WE_bar=0 for exactly one cycle;
- S_HOLD: MEM_WE_bar=1, MEM_ADDR and MEM_DATA unchanged.
REQ-020 On leaving S_HOLD:
- MEM_ADDR SHALL increment by 1, modulo 2^16 (0xFFFF wraps to 0x0000);
- the next state SHALL be S_DATA if the remaining count is nonzero, else S_CHECK.
REQ-021 Each data byte SHALL therefore occupy a minimum of 4 cycles, giving a peak rate of one byte per 4 clocks; IN_VALID=0 in S_DATA or S_CHECK SHALL stall the loader with no state change.
REQ-022 MEM_ADDR SHALL change only on the S_LEN_HI acceptance edge (loading the header address) and on the S_HOLD exit edge; it SHALL never change while MEM_WE_bar=0.
REQ-023 On accepting the CHECK byte:
- if it equals the checksum, the next state SHALL be S_DONE;
- otherwise the next state SHALL be S_ERROR.
REQ-024 S_DONE SHALL set DONE=1, CPU_RST_bar=1 and BUS_OE_bar=1, and SHALL remain there until RST.
REQ-025 S_ERROR SHALL set ERR=1, CPU_RST_bar=0 and BUS_OE_bar=1, and SHALL remain there until RST.
REQ-026 In all other states, CPU_RST_bar=0 and BUS_OE_bar=0.
REQ-027 All outputs SHALL be registered (glitch-free), with no combinational path from IN_VALID or IN_DATA to any output.

Reset
REQ-028 On a CLK edge with RST=1, the following SHALL take effect on that same edge, from any state including mid-write:
- state=S_ADDR_HI;
- MEM_ADDR=0x0000, MEM_DATA=0x00, remaining count=0, checksum=0x00;
- MEM_WE_bar=1, BUS_OE_bar=0, CPU_RST_bar=0;
- DONE=0, ERR=0.
REQ-029 IN_READY SHALL be 0 while RST=1 and SHALL become 1 on the first edge after RST deasserts.

Verification
REQ-030 Stream 12 34 00 02 AA 55 FF -> writes AA@0x1234 and 55@0x1235, one low MEM_WE_bar cycle each; then DONE=1, CPU_RST_bar=1.
REQ-031 Stream FF FF 00 02 01 02 03 -> writes 01@0xFFFF and 02@0x0000 (wrap); then DONE=1.
REQ-032 Stream 00 00 00 00 00 -> no write strobes; DONE=1 after 5 accepted bytes. Stream 00 00 00 00 01 -> ERR=1, CPU_RST_bar stays 0.
REQ-033 Stream 80 00 00 01 10 11 (bad checksum) -> write 10@0x8000 occurs; ERR=1, DONE=0, BUS_OE_bar=1.
REQ-034 Assert RST during S_STROBE -> MEM_WE_bar=1 on that edge, state=S_ADDR_HI; a following valid stream loads correctly.
REQ-035 IN_VALID toggled randomly across a 3-byte image -> identical memory contents to back-to-back delivery; MEM_ADDR never changes while MEM_WE_bar=0.
